// File: rtl/ppu_cmd_sequencer_if.sv
// rtl/ppu_cmd_sequencer_if.sv - command word stream in, single-square PPU update beats out
interface ppu_cmd_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:0] cmd_data;
  logic        receive;
  logic        board;
  logic [6:0]  square_update;
  logic [1:0]  square_state;
  logic [1:0]  ship_type;
  logic [2:0]  ship_section;
  logic        vert;
  logic        square_sel;

  modport master (
    output cmd_valid, cmd_data,
    input  cmd_ready, receive, board, square_update, square_state,
           ship_type, ship_section, vert, square_sel
  );

  modport slave (
    input  cmd_valid, cmd_data,
    output cmd_ready, receive, board, square_update, square_state,
           ship_type, ship_section, vert, square_sel
  );
endinterface

// File: rtl/ppu_cmd_sequencer.sv
// rtl/ppu_cmd_sequencer.sv - buffers CPU display commands and expands them into PPU square-update beats
// Optional: PPU_BLANK_SYNC_EN gates update strobes to frame_blank cycles.
module ppu_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int SQUARES    = 100
) (
  input  logic                  vga_clk,
  input  logic                  rst_n,
  ppu_cmd_sequencer_if.slave    bus,
  input  logic                  frame_blank,
  output logic                  busy,
  output logic                  cmd_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] OP_SQUARE = 2'b00;
  localparam logic [1:0] OP_SHIP   = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;

  typedef enum logic [1:0] {IDLE, LOAD, ISSUE, NEXT} fsm_t;
  fsm_t fsm_q, fsm_d;

  // FIFO stores only the decoded bits [23:5]; the reserved field is dropped at the door.
  logic [18:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, push, pop;
  logic [18:0] head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = bus.cmd_valid && !full;
  assign pop   = (fsm_q == LOAD);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge vga_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.cmd_data[23:5];
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  logic [1:0] h_op, h_state, h_type;
  logic       h_board, h_vert, h_sel;
  logic [6:0] h_sq;
  logic [2:0] h_sec;
  logic [7:0] h_sq8, len8;
  logic [3:0] h_col;
  logic       rej;

  assign h_op    = head[18:17];
  assign h_board = head[16];
  assign h_sq    = head[15:9];
  assign h_state = head[8:7];
  assign h_type  = head[6:5];
  assign h_sec   = head[4:2];
  assign h_vert  = head[1];
  assign h_sel   = head[0];
  assign h_sq8   = {1'b0, h_sq};
  assign len8    = {6'd0, h_type} + 8'd2;

  // Column of the head square from a compare ladder; no divider in the decode path.
  always_comb begin
    h_col = h_sq[3:0];
    for (int i = 1; i <= 9; i++)
      if (h_sq >= 7'(10 * i)) h_col = 4'(h_sq - 7'(10 * i));
  end

  always_comb begin
    rej = 1'b0;
    case (h_op)
      OP_SQUARE: rej = (h_sq8 > 8'd99);
      OP_SHIP:   rej = (h_sq8 > 8'd99) ||
                       (h_vert ? ((h_sq8 + 8'd10 * (len8 - 8'd1)) > 8'd99)
                               : (({4'd0, h_col} + len8) > 8'd10));
      OP_CLEAR:  rej = 1'b0;
      default:   rej = 1'b1;
    endcase
  end

  logic [1:0] op_q, st_q, ty_q;
  logic       board_q, vert_q, sel_q, err_q;
  logic [6:0] sq_q;
  logic [2:0] sec_q;
  logic [7:0] sq_step;
  logic       beat_on, fire, last_beat;

  assign beat_on = (fsm_q == ISSUE) || (fsm_q == NEXT);
`ifdef PPU_BLANK_SYNC_EN
  assign fire = beat_on && frame_blank;
`else
  assign fire = beat_on;
  logic unused_blank;
  assign unused_blank = frame_blank;
`endif

  assign sq_step = {1'b0, sq_q} + ((op_q == OP_SHIP && vert_q) ? 8'd10 : 8'd1);

  always_comb begin
    last_beat = 1'b1;
    case (op_q)
      OP_SHIP:  last_beat = (sec_q == ({1'b0, ty_q} + 3'd1));
      OP_CLEAR: last_beat = ({1'b0, sq_q} == 8'(SQUARES - 1));
      default:  last_beat = 1'b1;
    endcase
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) fsm_q <= IDLE;
    else        fsm_q <= fsm_d;
  end

  // NEXT is the held-beat state entered only when a beat cannot fire this cycle.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:        if (!empty) fsm_d = LOAD;
      LOAD:        fsm_d = rej ? IDLE : ISSUE;
      ISSUE, NEXT: if (fire) fsm_d = last_beat ? IDLE : ISSUE;
                   else      fsm_d = NEXT;
      default:     fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      board_q <= 1'b0;
      sq_q    <= '0;
      st_q    <= '0;
      ty_q    <= '0;
      sec_q   <= '0;
      vert_q  <= 1'b0;
      sel_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (fsm_q == LOAD) begin
        err_q <= rej;
        if (!rej) begin
          op_q    <= h_op;
          board_q <= h_board;
          case (h_op)
            OP_SHIP: begin
              sq_q   <= h_sq;
              st_q   <= 2'b11;
              ty_q   <= h_type;
              sec_q  <= 3'd0;
              vert_q <= h_vert;
              sel_q  <= 1'b0;
            end
            OP_CLEAR: begin
              sq_q   <= 7'd0;
              st_q   <= 2'b00;
              ty_q   <= 2'b00;
              sec_q  <= 3'd0;
              vert_q <= 1'b0;
              sel_q  <= 1'b0;
            end
            default: begin
              sq_q   <= h_sq;
              st_q   <= h_state;
              ty_q   <= h_type;
              sec_q  <= h_sec;
              vert_q <= h_vert;
              sel_q  <= h_sel;
            end
          endcase
        end
      end else if (fire && !last_beat) begin
        sq_q <= sq_step[6:0];
        if (op_q == OP_SHIP) sec_q <= sec_q + 3'd1;
      end
    end
  end

  logic [5:0] unused_bits;
  assign unused_bits = {bus.cmd_data[4:0], sq_step[7]};

  assign bus.cmd_ready     = !full;
  assign bus.receive       = fire;
  assign bus.board         = board_q;
  assign bus.square_update = sq_q;
  assign bus.square_state  = st_q;
  assign bus.ship_type     = ty_q;
  assign bus.ship_section  = sec_q;
  assign bus.vert          = vert_q;
  assign bus.square_sel    = sel_q;
  assign busy              = !empty || (fsm_q != IDLE);
  assign cmd_err           = err_q;

endmodule
